greedy_tokenizer: RTL and testbench
===================================

Name: greedy_tokenizer

Overview:
- Parametrised successor to the single-entry vocab/input matcher.
- Scans a NULL-terminated input string held in an input RAM against a packed vocabulary RAM of NULL-terminated entries.
- Emits a stream of token IDs using greedy longest-match; unknown characters are emitted as UNK.
- Sits between the byte-level input buffer and the embedding lookup stage of the tensor core front end.

Parameters:
- VOCAB_ADDR_WIDTH, 4, vocab RAM address width (vocab depth 2^N bytes).
- INPUT_ADDR_WIDTH, 4, input RAM address width.
- DATA_WIDTH, 8, character width.
- TOKEN_ID_WIDTH, 8, token ID width.
- NULL_CHAR, 0, terminator value.
- UNK_ID, all ones (TOKEN_ID_WIDTH bits), ID emitted for unmatched characters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins tokenizing; ignored while busy.
- vocab_addr  out  VOCAB_ADDR_WIDTH  vocab RAM read address.
- vocab_data  in  DATA_WIDTH  vocab RAM read data.
- input_addr  out  INPUT_ADDR_WIDTH  input RAM read address.
- input_data  in  DATA_WIDTH  input RAM read data.
- tok_valid  out  1  token output valid.
- tok_ready  in  1  downstream ready.
- tok_id  out  TOKEN_ID_WIDTH  matched token ID, or UNK_ID.
- tok_len  out  INPUT_ADDR_WIDTH+1  number of input chars consumed.
- tok_unk  out  1  token is UNK.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse when input is exhausted.
- vocab_overflow  out  1  sticky per run: vocab scan wrapped without a double NULL.

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port rst.
- Reset (including mid-operation): FSM goes to IDLE. All outputs are 0: addresses, tok_*, busy, done, vocab_overflow.
- RAM timing: both RAMs are synchronous read with 1-cycle latency. Data for the address driven in cycle n is sampled in cycle n+1.
- Vocab layout:
  - Entries are packed back to back, each NULL-terminated.
  - An empty entry (NULL immediately at an entry start) marks the end of the vocab.
  - Entry IDs count from 0 in storage order.
- FSM states: IDLE, POS_RD, POS_CHK, CMP_RD, CMP, SKIP_RD, SKIP, DECIDE, EMIT, DONE.
- IDLE:
  - On start, clear pos=0, best_len=0, vocab_overflow=0.
  - Assert busy and go to POS_RD.
- POS_RD / POS_CHK:
  - Read input[pos].
  - If the value is NULL, or pos has passed 2^INPUT_ADDR_WIDTH-1, go to DONE.
  - Otherwise set av=0, id=0, k=0 and go to CMP_RD.
- CMP_RD / CMP: read vocab[av] and input[pos+k], then compare.
  - Vocab char NULL with k==0: vocab end, go to DECIDE.
  - Vocab char NULL with k>0: full entry matched. If k>best_len, record best_len=k and best_id=id; ties keep the lower id. Then id++, av++, k=0, back to CMP_RD.
  - Characters equal and not NULL: av++, k++, back to CMP_RD.
  - Mismatch, or input index passes the end of the input RAM: go to SKIP_RD.
- SKIP_RD / SKIP:
  - Advance av until the vocab char is NULL.
  - Then av++, id++, k=0, back to CMP_RD.
- Vocab wrap: if av would wrap past 2^VOCAB_ADDR_WIDTH-1, set vocab_overflow and treat it as vocab end (DECIDE). Any partial match in progress is discarded.
- id saturation: if id would exceed UNK_ID-1, treat it as vocab end.
- DECIDE:
  - best_len>0: tok_id=best_id, tok_len=best_len, tok_unk=0, pos+=best_len.
  - Otherwise: tok_id=UNK_ID, tok_len=1, tok_unk=1, pos+=1.
  - Clear best_len, go to EMIT.
- EMIT:
  - Hold tok_valid=1 with tok_id, tok_len and tok_unk stable until tok_ready=1.
  - The handshake completes in the cycle valid and ready are both high; then go to POS_RD.
- DONE:
  - Pulse done for 1 cycle, drop busy, return to IDLE.
  - vocab_overflow holds until the next start.
- Empty input: done pulses with no tokens emitted.
- Empty vocab: every input char is emitted as UNK.

Decomposition:
- Package greedy_tokenizer_pkg holds:
  - the FSM state enum;
  - NULL_CHAR and UNK_ID default constants;
  - a token struct {id, len, unk}.
- One sub-module, tok_out_reg: a valid/ready output holding register that keeps token fields stable under backpressure.
- RAMs stay external.

Test Plan:
1. Basic longest match. Vocab "a\0ab\0b\0\0", input "abba\0", tok_ready=1 -> tokens (id1,len2), (id2,len1), (id0,len1), then done; vocab_overflow=0.
2. Unknown character. Same vocab, input "c\0" -> one token with tok_id=0xFF, tok_unk=1, tok_len=1, then done.
3. Empty input. Input "\0" -> done pulses 1 cycle after the input read, no tok_valid, busy then low.
4. Backpressure. Test 1 with tok_ready low for 5 cycles on the first token -> tok_id=1 and tok_len=2 held stable while tok_valid=1; the stream is otherwise unchanged.
5. Reset mid-run. Assert rst while in CMP -> next cycle all outputs 0, state IDLE. A new start reproduces the test 1 output exactly.
6. Tie and overflow.
   - Tie: vocab "ab\0ab\0\0", input "ab\0" -> tok_id=0.
   - Overflow: a 16-byte vocab with no double NULL -> vocab_overflow=1 and tokens still emitted.

Source files
------------

// File: rtl/greedy_tokenizer_pkg.sv
// greedy_tokenizer_pkg: shared FSM states, default constants and token record for the tokenizer.
package greedy_tokenizer_pkg;
   localparam int DEF_NULL_CHAR = 0;
   localparam int DEF_TOKEN_ID_WIDTH = 8;
   localparam int DEF_INPUT_ADDR_WIDTH = 4;
   localparam logic [DEF_TOKEN_ID_WIDTH-1:0] DEF_UNK_ID = '1;
   typedef enum logic [3:0] {
      IDLE, POS_RD, POS_CHK, CMP_RD, CMP, SKIP_RD, SKIP, DECIDE, EMIT, DONE
   } state_t;
   typedef struct packed {
      logic [DEF_TOKEN_ID_WIDTH-1:0]   id;
      logic [DEF_INPUT_ADDR_WIDTH:0]   len;
      logic                            unk;
   } tok_t;
endpackage

// File: rtl/greedy_tokenizer_tok_out_reg.sv
// tok_out_reg: valid/ready holding register keeping the token stable under backpressure.
module tok_out_reg
   import greedy_tokenizer_pkg::*;
#(
   parameter int W = $bits(tok_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_tok,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_tok
);
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_tok   <= '0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_tok   <= i_tok;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/greedy_tokenizer.sv
// greedy_tokenizer: greedy longest-match tokenizer over external input and packed vocab RAMs.
module greedy_tokenizer
   import greedy_tokenizer_pkg::*;
#(
   parameter int VOCAB_ADDR_WIDTH = 4,
   parameter int INPUT_ADDR_WIDTH = DEF_INPUT_ADDR_WIDTH,
   parameter int DATA_WIDTH = 8,
   parameter int TOKEN_ID_WIDTH = DEF_TOKEN_ID_WIDTH,
   parameter logic [DATA_WIDTH-1:0] NULL_CHAR = DATA_WIDTH'(DEF_NULL_CHAR),
   parameter logic [TOKEN_ID_WIDTH-1:0] UNK_ID = '1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr,
   input  logic [DATA_WIDTH-1:0]       vocab_data,
   output logic [INPUT_ADDR_WIDTH-1:0] input_addr,
   input  logic [DATA_WIDTH-1:0]       input_data,
   output logic                        tok_valid,
   input  logic                        tok_ready,
   output logic [TOKEN_ID_WIDTH-1:0]   tok_id,
   output logic [INPUT_ADDR_WIDTH:0]   tok_len,
   output logic                        tok_unk,
   output logic                        busy,
   output logic                        done,
   output logic                        vocab_overflow
);
   localparam int LW = INPUT_ADDR_WIDTH + 1;
   localparam int TW = TOKEN_ID_WIDTH + LW + 1;

   state_t                      r_state;
   logic [LW-1:0]               r_pos, r_k, r_best_len;
   logic [VOCAB_ADDR_WIDTH-1:0] r_av;
   logic [TOKEN_ID_WIDTH-1:0]   r_id, r_best_id;
   logic [LW-1:0]               w_idx, w_adv;
   logic [VOCAB_ADDR_WIDTH-1:0] w_av_inc;
   logic                        w_vnull, w_av_last, w_id_last, w_load, w_cmp, w_match;
   logic [TW-1:0]               w_tok, w_tok_q;

   assign w_idx     = r_pos + r_k;
   assign w_av_inc  = r_av + 1'b1;
   assign w_vnull   = vocab_data == NULL_CHAR;
   assign w_av_last = &r_av;
   assign w_id_last = r_id == UNK_ID - 1'b1;
   assign w_cmp     = r_state == CMP;
   assign w_match   = w_cmp && !w_idx[LW-1] && vocab_data == input_data;
   assign w_load    = r_state == DECIDE;
   assign w_adv     = (r_best_len != '0) ? r_best_len : LW'(1);
   assign w_tok     = (r_best_len != '0) ? {r_best_id, r_best_len, 1'b0} : {UNK_ID, LW'(1), 1'b1};
   assign {tok_id, tok_len, tok_unk} = w_tok_q;

   tok_out_reg #(.W(TW)) u_out (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_tok   (w_tok),
      .i_ready (tok_ready),
      .o_valid (tok_valid),
      .o_tok   (w_tok_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         vocab_addr     <= '0;
         input_addr     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         vocab_overflow <= 1'b0;
         r_pos          <= '0;
         r_k            <= '0;
         r_best_len     <= '0;
         r_best_id      <= '0;
         r_av           <= '0;
         r_id           <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_pos          <= '0;
               r_best_len     <= '0;
               vocab_overflow <= 1'b0;
               input_addr     <= '0;
               busy           <= 1'b1;
               r_state        <= POS_RD;
            end
            POS_RD: r_state <= POS_CHK;
            POS_CHK: if (input_data == NULL_CHAR || r_pos[LW-1]) begin
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= DONE;
            end else begin
               r_av       <= '0;
               r_id       <= '0;
               r_k        <= '0;
               vocab_addr <= '0;
               input_addr <= r_pos[LW-2:0];
               r_state    <= CMP_RD;
            end
            CMP_RD: r_state <= CMP;
            SKIP_RD: r_state <= SKIP;
            CMP, SKIP: begin
               // SKIP always runs with r_k cleared, so an entry end there never records a match
               if (w_vnull && w_cmp && r_k == '0) begin
                  r_state <= DECIDE;
               end else if (w_vnull) begin
                  if (r_k > r_best_len) begin
                     r_best_len <= r_k;
                     r_best_id  <= r_id;
                  end
                  if (w_av_last) begin
                     vocab_overflow <= 1'b1;
                     r_state        <= DECIDE;
                  end else if (w_id_last) begin
                     r_state <= DECIDE;
                  end else begin
                     r_av       <= w_av_inc;
                     vocab_addr <= w_av_inc;
                     r_id       <= r_id + 1'b1;
                     r_k        <= '0;
                     input_addr <= r_pos[LW-2:0];
                     r_state    <= CMP_RD;
                  end
               end else if (w_av_last) begin
                  vocab_overflow <= 1'b1;
                  r_state        <= DECIDE;
               end else begin
                  r_av       <= w_av_inc;
                  vocab_addr <= w_av_inc;
                  r_k        <= w_match ? r_k + 1'b1 : '0;
                  input_addr <= w_idx[LW-2:0] + 1'b1;
                  r_state    <= w_match ? CMP_RD : SKIP_RD;
               end
            end
            DECIDE: begin
               r_pos      <= r_pos + w_adv;
               r_best_len <= '0;
               r_state    <= EMIT;
            end
            EMIT: if (tok_valid && tok_ready) begin
               input_addr <= r_pos[LW-2:0];
               r_state    <= POS_RD;
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_greedy_tokenizer.sv
// tb_greedy_tokenizer: directed tests against a string-level greedy tokenizer model.
module tb_greedy_tokenizer;
   import greedy_tokenizer_pkg::*;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, tok_ready = 1'b1;
   logic [3:0] vocab_addr, input_addr;
   logic [7:0] vocab_data, input_data, tok_id;
   logic [4:0] tok_len;
   logic       tok_valid, tok_unk, busy, done, vocab_overflow;
   logic [7:0] vmem [16];
   logic [7:0] imem [16];
   int         n_cmp = 0, n_bad = 0, stall_left = 0;
   tok_t       exp_q [$];

   greedy_tokenizer dut (
      .clk(clk), .rst(rst), .start(start),
      .vocab_addr(vocab_addr), .vocab_data(vocab_data),
      .input_addr(input_addr), .input_data(input_data),
      .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_id(tok_id), .tok_len(tok_len), .tok_unk(tok_unk),
      .busy(busy), .done(done), .vocab_overflow(vocab_overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      vocab_data <= vmem[vocab_addr];
      input_data <= imem[input_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // '.' stands for the NULL terminator in both strings
   task automatic load(input string v, input string s);
      for (int i = 0; i < 16; i++) begin
         vmem[i] = 8'h00;
         imem[i] = 8'h00;
      end
      for (int i = 0; i < v.len(); i++) vmem[i] = (v[i] == 8'h2E) ? 8'h00 : v[i];
      for (int i = 0; i < s.len(); i++) imem[i] = (s[i] == 8'h2E) ? 8'h00 : s[i];
   endtask

   function automatic void build(output logic ovf);
      int   st [16];
      int   ln [16];
      int   n = 0, s = 0, e, pos = 0, bl, bi;
      logic vov = 1'b0, more = 1'b1, hit;
      tok_t t;
      while (more) begin
         if (s > 15) begin
            vov = 1'b1;
            more = 1'b0;
         end else if (vmem[s] == 8'h00) begin
            more = 1'b0;
         end else begin
            e = s;
            while (e < 16 && vmem[e] != 8'h00) e++;
            if (e == 16) begin
               vov = 1'b1;
               more = 1'b0;
            end else begin
               st[n] = s;
               ln[n] = e - s;
               n++;
               s = e + 1;
            end
         end
      end
      exp_q.delete();
      while (pos < 16 && imem[pos] != 8'h00) begin
         bl = 0;
         bi = 0;
         for (int i = 0; i < n; i++) begin
            if (ln[i] > bl && pos + ln[i] <= 16) begin
               hit = 1'b1;
               for (int j = 0; j < ln[i]; j++) if (imem[pos + j] != vmem[st[i] + j]) hit = 1'b0;
               if (hit) begin
                  bl = ln[i];
                  bi = i;
               end
            end
         end
         t.id  = (bl > 0) ? 8'(bi) : DEF_UNK_ID;
         t.len = (bl > 0) ? 5'(bl) : 5'd1;
         t.unk = (bl == 0);
         exp_q.push_back(t);
         pos += (bl > 0) ? bl : 1;
      end
      ovf = vov && imem[0] != 8'h00;
   endfunction

   tok_t prev;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      tok_t t;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", tok_valid, 1);
            check("hold_tok", {tok_id, tok_len, tok_unk}, prev);
         end
         if (tok_valid && tok_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_token: got id %0h len %0d, none expected", tok_id, tok_len);
            end else begin
               t = exp_q.pop_front();
               check("tok_id", tok_id, t.id);
               check("tok_len", tok_len, t.len);
               check("tok_unk", tok_unk, t.unk);
            end
         end
         prev_stall = tok_valid && !tok_ready;
         prev = {tok_id, tok_len, tok_unk};
      end
   end

   task automatic check_zero(input string name);
      check(name, {vocab_addr, input_addr, tok_valid, tok_id, tok_len, tok_unk, busy, done, vocab_overflow}, 0);
   endtask

   task automatic run(input string name, input int stall, output int lat);
      logic eo;
      build(eo);
      @(posedge clk); #1;
      start = 1'b1;
      stall_left = stall;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_busy"}, busy, 1);
      lat = 0;
      while (!done && lat < 3000) begin
         tok_ready = !(tok_valid && stall_left > 0);
         if (tok_valid && stall_left > 0) stall_left--;
         @(posedge clk); #1;
         lat++;
      end
      tok_ready = 1'b1;
      check({name, "_done"}, done, 1);
      check({name, "_busy_low"}, busy, 0);
      check({name, "_ovf"}, vocab_overflow, eo);
      check({name, "_left"}, exp_q.size(), 0);
      @(posedge clk); #1;
      check({name, "_done_pulse"}, done, 0);
      check({name, "_ovf_hold"}, vocab_overflow, eo);
   endtask

   initial begin
      int   lat, g;
      logic o;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_outputs");
      rst = 1'b0;

      load("a.ab.b..", "abba.");
      build(o);
      check("model_t1_n", exp_q.size(), 3);
      check("model_t1_0", {exp_q[0].id, exp_q[0].len, exp_q[0].unk}, {8'd1, 5'd2, 1'b0});
      check("model_t1_1", {exp_q[1].id, exp_q[1].len, exp_q[1].unk}, {8'd2, 5'd1, 1'b0});
      check("model_t1_2", {exp_q[2].id, exp_q[2].len, exp_q[2].unk}, {8'd0, 5'd1, 1'b0});
      check("model_t1_ovf", o, 0);
      run("t1", 0, lat);

      load("a.ab.b..", "c.");
      build(o);
      check("model_t2", {exp_q[0].id, exp_q[0].len, exp_q[0].unk}, {8'hFF, 5'd1, 1'b1});
      run("t2", 0, lat);

      load("a.ab.b..", ".");
      run("t3", 0, lat);
      check("t3_latency", lat, 2);

      load("a.ab.b..", "abba.");
      run("t4", 5, lat);

      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      g = 0;
      while (dut.r_state != CMP && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      check("t5_reach_cmp", dut.r_state == CMP, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("t5_reset_outputs");
      check("t5_state", dut.r_state, IDLE);
      rst = 1'b0;
      run("t5", 0, lat);

      load("ab.ab..", "ab.");
      build(o);
      check("model_tie", {exp_q[0].id, exp_q[0].len}, {8'd0, 5'd2});
      run("t6_tie", 0, lat);

      load("a.a.a.a.a.a.a.a.", "ab.");
      build(o);
      check("model_ovf", o, 1);
      check("model_ovf_n", exp_q.size(), 2);
      run("t6_ovf", 0, lat);
      repeat (3) @(posedge clk);
      #1;
      check("t6_ovf_sticky", vocab_overflow, 1);

      load(".", "ab.");
      run("t7_empty_vocab", 0, lat);

      load("a.ab.b..", "abba.");
      run("t8_ovf_clear", 0, lat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
